// File: rtl/li_credit_sender_if.sv
// Link-side bundle for li_credit_sender: upstream valid/bp input, registered link output, credit return.
// master = environment driving tokens and credits, slave = the sender itself.
interface li_credit_sender_if #(
  parameter int Width    = 8,
  parameter int CntWidth = 3
);
  logic [Width-1:0]    d;
  logic                d_valid;
  logic                d_bp;
  logic [Width-1:0]    q;
  logic                q_valid;
  logic                credit_in;
  logic [CntWidth-1:0] credits_avail;
  logic                err_overflow;

  modport master (
    output d, d_valid, credit_in,
    input  d_bp, q, q_valid, credits_avail, err_overflow
  );

  modport slave (
    input  d, d_valid, credit_in,
    output d_bp, q, q_valid, credits_avail, err_overflow
  );
endinterface

// File: rtl/li_credit_sender.sv
// Transmit end of a credit-based latency-insensitive link; backpressure comes only from the local credit count.
// Optional sticky overflow detection is built when LLPM_CREDIT_OVERFLOW_CHECK_EN is defined.
module li_credit_sender #(
  parameter string Name     = "",
  parameter int    Width    = 8,
  parameter int    Credits  = 4,
  parameter int    CntWidth = 3
) (
  input logic               clk,
  input logic               resetn,
  li_credit_sender_if.slave bus
);

  localparam logic [CntWidth-1:0] CMax = CntWidth'(Credits);

  logic [CntWidth-1:0] r_count;
  logic [Width-1:0]    r_q;
  logic                r_q_valid;
  logic                w_has_credit;
  logic                w_send;

  // d_bp depends only on the registered count so no input reaches it combinationally
  assign w_has_credit      = (r_count != '0);
  assign w_send            = bus.d_valid && w_has_credit;
  assign bus.d_bp          = !w_has_credit;
  assign bus.q             = r_q;
  assign bus.q_valid       = r_q_valid;
  assign bus.credits_avail = r_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= CMax;
    end else begin
      case ({w_send, bus.credit_in})
        2'b10:   r_count <= r_count - 1'b1;
        2'b01:   if (r_count != CMax) r_count <= r_count + 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // link register: data only loads on a send, valid is a single-cycle pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q_valid <= 1'b0;
      r_q       <= '0;
    end else begin
      r_q_valid <= w_send;
      if (w_send) r_q <= bus.d;
    end
  end

`ifdef LLPM_CREDIT_OVERFLOW_CHECK_EN
  logic w_overflow;
  logic r_err_overflow;

  assign w_overflow       = bus.credit_in && !w_send && (r_count == CMax);
  assign bus.err_overflow = r_err_overflow;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_overflow <= 1'b0;
    end else if (w_overflow) begin
      r_err_overflow <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (resetn && w_overflow)
      $display("%s: credit overflow, credit returned while count already %0d", Name, Credits);
  end
`endif
`else
  assign bus.err_overflow = 1'b0;
`endif

`ifdef LLPM_DEBUG_HOOK_EN
  // debug hook, silent for unnamed instances
  always_ff @(posedge clk) begin
    if (resetn && Name != "")
      $display("%s q_valid=%0b q=%h count=%0d", Name, r_q_valid, r_q, r_count);
  end
`endif

endmodule

// File: tb/tb_li_credit_sender.sv
// Randomized and directed bench for li_credit_sender against a credit-accounting reference model.
module tb_li_credit_sender;
  localparam int Width    = 8;
  localparam int Credits  = 4;
  localparam int CntWidth = 3;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  // reference model state
  int         m_cnt;
  logic       m_qv;
  logic [7:0] m_q;
  logic       m_err;

  // receiver-side accounting for the random phase
  int rx_tokens;
  int pending;

  li_credit_sender_if #(.Width(Width), .CntWidth(CntWidth)) bus ();

  li_credit_sender #(
    .Name     ("tb_sender"),
    .Width    (Width),
    .Credits  (Credits),
    .CntWidth (CntWidth)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = Credits;
    m_qv  = 1'b0;
    m_q   = '0;
    m_err = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".q_valid"}, 32'(bus.q_valid), 32'(m_qv));
    chk({tag, ".q"}, 32'(bus.q), 32'(m_q));
    chk({tag, ".credits"}, 32'(bus.credits_avail), 32'(m_cnt));
    chk({tag, ".d_bp"}, 32'(bus.d_bp), 32'(m_cnt == 0));
    chk({tag, ".err"}, 32'(bus.err_overflow), 32'(m_err));
  endtask

  // one clock: apply inputs, advance the model by the credit rules, compare after the edge
  task automatic step(input string tag, input logic dv, input logic [7:0] dd, input logic ci);
    logic snd;
    bus.d_valid   = dv;
    bus.d         = dd;
    bus.credit_in = ci;
    chk({tag, ".bp_pre"}, 32'(bus.d_bp), 32'(m_cnt == 0));
    snd = dv && (m_cnt > 0);
    @(posedge clk);
    #1;
`ifdef LLPM_CREDIT_OVERFLOW_CHECK_EN
    if (ci && !snd && m_cnt == Credits) m_err = 1'b1;
`endif
    m_cnt = m_cnt - int'(snd) + int'(ci);
    if (m_cnt > Credits) m_cnt = Credits;
    m_qv = snd;
    if (snd) m_q = dd;
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] toks[5];
    checks = 0;
    errors = 0;
    toks[0] = 8'h11; toks[1] = 8'h22; toks[2] = 8'h33; toks[3] = 8'h44; toks[4] = 8'h55;
    bus.d = '0; bus.d_valid = 1'b0; bus.credit_in = 1'b0;
    resetn = 1'b0;
    model_reset();
    #23 resetn = 1'b1;
    @(posedge clk); #1;
    check_outputs("reset");

    // burst of five tokens with no credit return; the fifth must stall
    for (int i = 0; i < 5; i++) step("burst", 1'b1, toks[i], 1'b0);
    chk("burst.drained", 32'(bus.credits_avail), 32'd0);

    // credit arrives while 0x55 waits: one-cycle turnaround
    step("turn.ci", 1'b1, 8'h55, 1'b1);
    chk("turn.cnt1", 32'(bus.credits_avail), 32'd1);
    step("turn.send", 1'b1, 8'h55, 1'b0);
    chk("turn.q55", 32'(bus.q), 32'h55);

    // refill to 2, then send and return together for six cycles
    step("fill", 1'b0, 8'h00, 1'b1);
    step("fill", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) step("netzero", 1'b1, 8'($urandom), 1'b1);
    chk("netzero.cnt", 32'(bus.credits_avail), 32'd2);

    // fill to full, then an extra credit overflows
    step("fill", 1'b0, 8'h00, 1'b1);
    step("fill", 1'b0, 8'h00, 1'b1);
    step("ovf", 1'b0, 8'h00, 1'b1);
    step("ovf.hold", 1'b0, 8'h00, 1'b0);
    step("ovf.hold", 1'b0, 8'h00, 1'b0);

    // three sends leave count=1 with q_valid high, then reset asynchronously
    for (int i = 0; i < 3; i++) step("preRst", 1'b1, 8'hA0 + 8'(i), 1'b0);
    chk("preRst.qv", 32'(bus.q_valid), 32'd1);
    bus.d_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_outputs("asyncRst");
    #3 resetn = 1'b1;
    @(posedge clk); #1;
    check_outputs("postRst");

    // random traffic against a receiver that returns credits after random delays
    rx_tokens = 0;
    pending   = 0;
    for (int c = 0; c < 400; c++) begin
      logic ci;
      logic dv;
      ci = (pending > 0) && ($urandom_range(0, 2) != 0);
      dv = ($urandom_range(0, 3) != 0);
      step("rand", dv, 8'($urandom), ci);
      if (ci) pending--;
      if (bus.q_valid) rx_tokens++;
      chk("conserve", 32'(int'(bus.credits_avail) + rx_tokens + pending), 32'(Credits));
      if (rx_tokens > 0 && $urandom_range(0, 1) == 1) begin
        rx_tokens--;
        pending++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
